// File: rtl/rgb_to_yuv_encoder.sv
// rgb_to_yuv_encoder: reads packed RGB pixels from SRAM four at a time,
// converts them to YUV with one shared converter, averages U/V over
// horizontal pixel pairs and writes the Y, U and V planes back to SRAM.
module rgb_to_yuv_encoder #(
  parameter logic [17:0] RGB_BASE   = 18'd146944,
  parameter logic [17:0] Y_BASE     = 18'd0,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600,
  parameter logic [14:0] NUM_GROUPS = 15'd19200
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        enc_start,
  output logic        enc_done,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_RD0   = 4'd1;
  localparam logic [3:0] S_RD1   = 4'd2;
  localparam logic [3:0] S_RD2   = 4'd3;
  localparam logic [3:0] S_RD3   = 4'd4;
  localparam logic [3:0] S_RD4   = 4'd5;
  localparam logic [3:0] S_RD5   = 4'd6;
  localparam logic [3:0] S_WAIT0 = 4'd7;
  localparam logic [3:0] S_WAIT1 = 4'd8;
  localparam logic [3:0] S_CALC  = 4'd9;
  localparam logic [3:0] S_WR_Y0 = 4'd10;
  localparam logic [3:0] S_WR_Y1 = 4'd11;
  localparam logic [3:0] S_WR_U  = 4'd12;
  localparam logic [3:0] S_WR_V  = 4'd13;

  logic [3:0]  state;
  logic [14:0] g;
  logic [17:0] g_ext;
  logic [17:0] rgb_group_addr;
  logic        last_group;

  logic [15:0] rd_word [6];
  logic [7:0]  y_pix [4];
  logic [7:0]  u_pix [4];
  logic [7:0]  v_pix [4];

  logic        cvt_en;
  logic [1:0]  cvt_idx;
  logic [7:0]  cvt_r, cvt_g, cvt_b;
  logic signed [17:0] r_s, g_s, b_s;
  logic signed [17:0] y_sum, u_sum, v_sum;
  logic [7:0]  y_val, u_val, v_val;

  logic [8:0]  ua_sum, ub_sum, va_sum, vb_sum;

  // Saturate a signed intermediate to the 0..255 pixel range.
  function automatic logic [7:0] clip8(input logic signed [17:0] x);
    if (x < 18'sd0)
      return 8'd0;
    else if (x > 18'sd255)
      return 8'hFF;
    else
      return x[7:0];
  endfunction

  assign g_ext          = {3'd0, g};
  assign rgb_group_addr = RGB_BASE + (g_ext << 2) + (g_ext << 1);
  assign last_group     = (g == NUM_GROUPS - 15'd1);

  // Route the bytes of whichever pixel has just become complete into the converter.
  always_comb begin
    cvt_en  = 1'b0;
    cvt_idx = 2'd0;
    cvt_r   = 8'd0;
    cvt_g   = 8'd0;
    cvt_b   = 8'd0;
    case (state)
      S_RD4: begin
        cvt_en  = 1'b1;
        cvt_idx = 2'd0;
        cvt_r   = rd_word[0][15:8];
        cvt_g   = rd_word[0][7:0];
        cvt_b   = rd_word[1][15:8];
      end
      S_RD5: begin
        cvt_en  = 1'b1;
        cvt_idx = 2'd1;
        cvt_r   = rd_word[1][7:0];
        cvt_g   = rd_word[2][15:8];
        cvt_b   = rd_word[2][7:0];
      end
      S_WAIT1: begin
        cvt_en  = 1'b1;
        cvt_idx = 2'd2;
        cvt_r   = rd_word[3][15:8];
        cvt_g   = rd_word[3][7:0];
        cvt_b   = rd_word[4][15:8];
      end
      S_CALC: begin
        cvt_en  = 1'b1;
        cvt_idx = 2'd3;
        cvt_r   = rd_word[4][7:0];
        cvt_g   = rd_word[5][15:8];
        cvt_b   = rd_word[5][7:0];
      end
      default: begin
        cvt_en = 1'b0;
      end
    endcase
  end

  assign r_s = $signed({10'd0, cvt_r});
  assign g_s = $signed({10'd0, cvt_g});
  assign b_s = $signed({10'd0, cvt_b});

  assign y_sum = 18'sd66 * r_s + 18'sd129 * g_s + 18'sd25 * b_s + 18'sd128;
  assign u_sum = 18'sd112 * b_s - 18'sd38 * r_s - 18'sd74 * g_s + 18'sd128;
  assign v_sum = 18'sd112 * r_s - 18'sd94 * g_s - 18'sd18 * b_s + 18'sd128;

  assign y_val = clip8((y_sum >>> 8) + 18'sd16);
  assign u_val = clip8((u_sum >>> 8) + 18'sd128);
  assign v_val = clip8((v_sum >>> 8) + 18'sd128);

  assign ua_sum = {1'b0, u_pix[0]} + {1'b0, u_pix[1]} + 9'd1;
  assign ub_sum = {1'b0, u_pix[2]} + {1'b0, u_pix[3]} + 9'd1;
  assign va_sum = {1'b0, v_pix[0]} + {1'b0, v_pix[1]} + 9'd1;
  assign vb_sum = {1'b0, v_pix[2]} + {1'b0, v_pix[3]} + 9'd1;

  // Capture each RGB word two cycles after its address was issued.
  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 6; i++) rd_word[i] <= 16'd0;
    end else begin
      case (state)
        S_RD2:   rd_word[0] <= SRAM_read_data;
        S_RD3:   rd_word[1] <= SRAM_read_data;
        S_RD4:   rd_word[2] <= SRAM_read_data;
        S_RD5:   rd_word[3] <= SRAM_read_data;
        S_WAIT0: rd_word[4] <= SRAM_read_data;
        S_WAIT1: rd_word[5] <= SRAM_read_data;
        default: rd_word[0] <= rd_word[0];
      endcase
    end
  end

  // Register the converted pixel into its slot within the group.
  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) begin
        y_pix[i] <= 8'd0;
        u_pix[i] <= 8'd0;
        v_pix[i] <= 8'd0;
      end
    end else if (cvt_en) begin
      y_pix[cvt_idx] <= y_val;
      u_pix[cvt_idx] <= u_val;
      v_pix[cvt_idx] <= v_val;
    end
  end

  // Sequence the fixed 13-cycle group and register the SRAM outputs for the next state.
  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      state           <= S_IDLE;
      g               <= 15'd0;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      SRAM_we_n       <= 1'b1;
      enc_done        <= 1'b0;
    end else begin
      enc_done  <= 1'b0;
      SRAM_we_n <= 1'b1;
      case (state)
        S_IDLE: begin
          if (enc_start) begin
            g            <= 15'd0;
            SRAM_address <= RGB_BASE;
            state        <= S_RD0;
          end
        end
        S_RD0: begin
          SRAM_address <= SRAM_address + 18'd1;
          state        <= S_RD1;
        end
        S_RD1: begin
          SRAM_address <= SRAM_address + 18'd1;
          state        <= S_RD2;
        end
        S_RD2: begin
          SRAM_address <= SRAM_address + 18'd1;
          state        <= S_RD3;
        end
        S_RD3: begin
          SRAM_address <= SRAM_address + 18'd1;
          state        <= S_RD4;
        end
        S_RD4: begin
          SRAM_address <= SRAM_address + 18'd1;
          state        <= S_RD5;
        end
        S_RD5:   state <= S_WAIT0;
        S_WAIT0: state <= S_WAIT1;
        S_WAIT1: state <= S_CALC;
        S_CALC: begin
          SRAM_address    <= Y_BASE + (g_ext << 1);
          SRAM_write_data <= {y_pix[0], y_pix[1]};
          SRAM_we_n       <= 1'b0;
          state           <= S_WR_Y0;
        end
        S_WR_Y0: begin
          SRAM_address    <= SRAM_address + 18'd1;
          SRAM_write_data <= {y_pix[2], y_pix[3]};
          SRAM_we_n       <= 1'b0;
          state           <= S_WR_Y1;
        end
        S_WR_Y1: begin
          SRAM_address    <= U_BASE + g_ext;
          SRAM_write_data <= {ua_sum[8:1], ub_sum[8:1]};
          SRAM_we_n       <= 1'b0;
          state           <= S_WR_U;
        end
        S_WR_U: begin
          SRAM_address    <= V_BASE + g_ext;
          SRAM_write_data <= {va_sum[8:1], vb_sum[8:1]};
          SRAM_we_n       <= 1'b0;
          enc_done        <= last_group;
          state           <= S_WR_V;
        end
        S_WR_V: begin
          if (last_group) begin
            state <= S_IDLE;
          end else begin
            g            <= g + 15'd1;
            SRAM_address <= rgb_group_addr + 18'd6;
            state        <= S_RD0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
